// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the CPU data-memory bridge: access size codes,
// FSM state encoding and default parameters.
package dmem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int ADDR_W_DEF  = 7;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// CPU-side and RAM-side signals of the data-memory bridge.
// RAM handshake: mem_req rises with a stable address/be/wdata/we and is held
// until mem_ack is seen high on a rising clk edge; that edge completes it.
interface dmem_bridge_if #(
    parameter int ADDR_W = 7
);
    logic              cpu_re;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [1:0]        cpu_size;
    logic              cpu_unsigned;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic              cpu_misalign;
    logic              cpu_err;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    // The bridge itself
    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
        input  mem_ack, mem_rdata,
        output cpu_rdata, cpu_stall, cpu_misalign, cpu_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    // The CPU and RAM around the bridge
    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_size, cpu_unsigned,
        output mem_ack, mem_rdata,
        input  cpu_rdata, cpu_stall, cpu_misalign, cpu_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for byte/half/word accesses: store byte enables and
// replication, load lane extraction with sign/zero extension, misalignment.
module dmem_lane_align
    import dmem_bridge_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        zext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    // Little-endian: lane 0 is bits [7:0]
    assign half_sel = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    assign byte_sel = lane[0] ? half_sel[15:8] : half_sel[7:0];

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = rdata_raw;
        misalign  = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = zext ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = zext ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                misalign  = lane[0];
            end
            default: misalign = (lane != 2'b00);
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the single-cycle CPU data port to a handshaked RAM, stalling the
// CPU for the duration of each access and aborting after a timeout.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    dmem_bridge_if.slave       bus,
    output state_t             dbg_state
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic              we_q;
    logic              err_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       data_q;

    logic              in_idle;
    logic              req_any;
    logic              access;
    logic              timeout_hit;
    logic [1:0]        al_lane;
    logic [1:0]        al_size;
    logic              al_zext;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_rdata;
    logic              al_misalign;
    logic              unused_addr_bits;

    assign in_idle          = (state_q == IDLE);
    assign req_any          = bus.cpu_re | bus.cpu_we;
    assign timeout_hit      = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign unused_addr_bits = ^bus.cpu_addr[31:ADDR_W+2];
    assign dbg_state        = state_q;

    // One aligner serves both directions: live CPU inputs in IDLE for
    // be/wdata/misalign, the captured access afterwards for load extraction.
    assign al_lane = in_idle ? bus.cpu_addr[1:0]  : lane_q;
    assign al_size = in_idle ? bus.cpu_size       : size_q;
    assign al_zext = in_idle ? bus.cpu_unsigned   : zext_q;
    assign access  = req_any & ~al_misalign;

    dmem_lane_align u_align (
        .lane      (al_lane),
        .size      (al_size),
        .zext      (al_zext),
        .wdata     (bus.cpu_wdata),
        .rdata_raw (data_q),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .rdata_ext (al_rdata),
        .misalign  (al_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (access) state_d = REQ;
            REQ:     if (bus.mem_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            waddr_q <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            zext_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (access) begin
                        waddr_q <= bus.cpu_addr[ADDR_W+1:2];
                        lane_q  <= bus.cpu_addr[1:0];
                        size_q  <= bus.cpu_size;
                        zext_q  <= bus.cpu_unsigned;
                        we_q    <= bus.cpu_we;
                        be_q    <= al_be;
                        wdata_q <= al_wdata;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        data_q  <= '0;
                    end
                end
                REQ: begin
                    // An ack on the last allowed cycle still wins over the abort
                    if (bus.mem_ack) begin
                        if (!we_q) data_q <= bus.mem_rdata;
                    end else if (timeout_hit) begin
                        err_q  <= 1'b1;
                        data_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.cpu_rdata    = '0;
        bus.cpu_stall    = 1'b0;
        bus.cpu_misalign = 1'b0;
        bus.cpu_err      = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_be       = '0;
        bus.mem_wdata    = '0;
        // Outputs are forced low while reset is asserted, even mid-access
        if (rst) begin
            bus.mem_addr  = waddr_q;
            bus.mem_be    = be_q;
            bus.mem_wdata = wdata_q;
            case (state_q)
                IDLE: begin
                    bus.cpu_stall    = access;
                    bus.cpu_misalign = req_any & al_misalign;
                end
                REQ: begin
                    bus.mem_req   = 1'b1;
                    bus.mem_we    = we_q;
                    bus.cpu_stall = 1'b1;
                end
                DONE: begin
                    bus.cpu_err   = err_q;
                    bus.cpu_rdata = we_q ? 32'h0 : al_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed cases plus randomized
// accesses against a byte-level RAM model and scoreboard.
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  localparam int AW = 7;
  localparam int TO = 15;

  logic   clk = 1'b0;
  logic   rst = 1'b0;
  state_t dbg_state;

  dmem_bridge_if #(.ADDR_W(AW)) bus ();

  dmem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] ram [128];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    if (size == SZ_BYTE) return 1;
    if (size == SZ_HALF) return 2;
    return 4;
  endfunction

  function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    return (int'(addr[1:0]) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
    logic [3:0] be;
    int n    = nbytes(size);
    int base = int'(addr[1:0]);
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] w;
    int n = nbytes(size);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
    longint v = 0;
    int n     = nbytes(size);
    int base  = int'(addr[1:0]);
    for (int k = 0; k < n; k++) v += longint'(word[8*(base+k) +: 8]) << (8*k);
    if (!uns && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
    return 32'(v);
  endfunction

  // ---------------- driver ----------------
  // Entered and left 1 time unit after a rising edge. delay = number of REQ
  // cycles before the one carrying mem_ack; delay >= TO never acks.
  task automatic do_access(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                           input int delay, input string tag);
    bit          mis, acc, to, done;
    int          n_stall, n_req, exp_req;
    logic [AW-1:0] wa;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    mis  = is_misaligned(addr, size);
    acc  = (re || we) && !mis;
    wa   = addr[AW+1:2];
    ebe  = model_be(addr, size);
    ewd  = model_wdata(wdata, size);
    bus.cpu_re       = re;
    bus.cpu_we       = we;
    bus.cpu_addr     = addr;
    bus.cpu_wdata    = wdata;
    bus.cpu_size     = size;
    bus.cpu_unsigned = uns;
    if (!acc) begin
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
      @(negedge clk);
      check({tag, "/misalign"}, bus.cpu_misalign, (re || we) && mis);
      check({tag, "/stall"}, bus.cpu_stall, 0);
      check({tag, "/mem_req"}, bus.mem_req, 0);
      check({tag, "/rdata"}, bus.cpu_rdata, 0);
      @(posedge clk); #1;
      bus.cpu_re = 1'b0;
      bus.cpu_we = 1'b0;
      return;
    end
    to      = (delay >= TO);
    exp_req = to ? TO : delay + 1;
    exp_q.push_back((we || to) ? 32'h0 : model_load(ram[wa], addr, size, uns));
    n_stall = 0;
    n_req   = 0;
    done    = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus.mem_req) begin
        bus.mem_ack   = (n_req == delay);
        bus.mem_rdata = bus.mem_ack ? ram[wa] : $urandom;
      end else begin
        // Stray acks outside REQ must be ignored
        bus.mem_ack   = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      if (bus.cpu_stall) n_stall++;
      if (bus.mem_req) begin
        check({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'(wa));
        check({tag, "/mem_be"}, 32'(bus.mem_be), 32'(ebe));
        check({tag, "/mem_we"}, bus.mem_we, we);
        if (we) check({tag, "/mem_wdata"}, bus.mem_wdata, ewd);
        n_req++;
      end
      if (!bus.cpu_stall) begin
        done = 1;
        check({tag, "/stall_cycles"}, n_stall, exp_req + 1);
        check({tag, "/req_cycles"}, n_req, exp_req);
        check({tag, "/err"}, bus.cpu_err, to);
        check({tag, "/rdata"}, bus.cpu_rdata, exp_q.pop_front());
        check({tag, "/misalign_done"}, bus.cpu_misalign, 0);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      check({tag, "/cycle_budget"}, 0, 1);
      exp_q.delete();
    end
    if (we && !to) begin
      for (int i = 0; i < 4; i++) if (ebe[i]) ram[wa][8*i +: 8] = ewd[8*i +: 8];
    end
    bus.cpu_re  = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cpu_re       = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_wdata    = '0;
    bus.cpu_size     = '0;
    bus.cpu_unsigned = 1'b0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = '0;
    for (int i = 0; i < 128; i++) ram[i] = $urandom;

    // Reset state
    #12;
    check("rst/cpu_rdata", bus.cpu_rdata, 0);
    check("rst/cpu_stall", bus.cpu_stall, 0);
    check("rst/cpu_err", bus.cpu_err, 0);
    check("rst/mem_req", bus.mem_req, 0);
    check("rst/mem_we", bus.mem_we, 0);
    check("rst/mem_be", 32'(bus.mem_be), 0);
    check("rst/mem_addr", 32'(bus.mem_addr), 0);
    check("rst/mem_wdata", bus.mem_wdata, 0);
    check("rst/state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    ram[4] = 32'hDEADBEEF;
    do_access(1, 0, 32'h10, 32'h0, SZ_WORD, 0, 0, "lw");
    do_access(0, 1, 32'h13, 32'h000000A5, SZ_BYTE, 0, 3, "sb");
    do_access(1, 0, 32'h10, 32'h0, SZ_WORD, 0, 1, "lw_after_sb");
    ram[4] = 32'h1280FF34;
    do_access(1, 0, 32'h12, 32'h0, SZ_BYTE, 0, 0, "lb");
    do_access(1, 0, 32'h12, 32'h0, SZ_BYTE, 1, 2, "lbu");
    do_access(1, 0, 32'h11, 32'h0, SZ_HALF, 0, 0, "lh_mis");
    do_access(1, 0, 32'h22, 32'h0, 2'b11, 0, 0, "lw11_mis");
    do_access(1, 0, 32'h20, 32'h0, SZ_WORD, 0, TO + 10, "lw_timeout");
    check("timeout/state", 32'(dbg_state), 32'(IDLE));
    do_access(1, 0, 32'h24, 32'h0, SZ_HALF, 1, TO - 1, "lhu_last_cycle");
    do_access(1, 1, 32'h2A, 32'h1234BEEF, SZ_HALF, 0, 1, "rw_is_write");

    // Reset in the middle of REQ
    bus.cpu_re   = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h40;
    bus.cpu_size = SZ_WORD;
    bus.mem_ack  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid/mem_req_before", bus.mem_req, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid/mem_req", bus.mem_req, 0);
    check("rst_mid/cpu_stall", bus.cpu_stall, 0);
    check("rst_mid/state", 32'(dbg_state), 32'(IDLE));
    bus.cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    do_access(0, 1, 32'h44, 32'hCAFEF00D, SZ_WORD, 0, 2, "sw_after_rst");
    do_access(1, 0, 32'h44, 32'h0, SZ_WORD, 0, 0, "lw_after_rst");

    // Randomized accesses
    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r, d;
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = a[1:0] & ~2'(nbytes(sz) - 1);
      r  = $urandom_range(0, 19);
      d  = (r < 16) ? $urandom_range(0, 3) : (r < 18) ? TO - 1 : TO + 2;
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, sz,
                1'($urandom_range(0, 1)), d, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
